// File: rtl/regfile_pkg.sv
// Shared encodings for the multi-port register file: write-back source select and fixed register numbers.
package regfile_pkg;

   typedef enum logic [1:0] {
      WB_SRC_MEM  = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_LINK = 2'd2,
      WB_SRC_RSVD = 2'd3
   } wb_src_e;

   localparam int REG_ZERO = 0;
   localparam int REG_V0   = 2;
   localparam int REG_A0   = 4;
   localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_sb.sv
// Hazard scoreboard: saturating pending-write counter per register, sticky overflow flag, per-port busy lookup.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int CNT_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue,
   input  logic [ADDR_W-1:0]     issue_addr,
   input  logic                  commit,
   input  logic [ADDR_W-1:0]     commit_addr,
   input  logic [NRD*ADDR_W-1:0] raddr,
   input  logic [NRD-1:0]        fwd,
   output logic [NRD-1:0]        busy,
   output logic                  sb_ovf
);

   localparam int               DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt [DEPTH];
   logic             do_issue;
   logic             do_commit;
   logic             same_reg;
   logic             refuse;

   always_comb begin
      do_issue  = issue  && (issue_addr  != ADDR_W'(REG_ZERO));
      do_commit = commit && (commit_addr != ADDR_W'(REG_ZERO));
      // An issue and a commit to the same register cancel out, so neither can overflow nor underflow.
      same_reg  = do_issue && do_commit && (issue_addr == commit_addr);
      refuse    = do_issue && !same_reg && (cnt[issue_addr] == CNT_MAX);
   end

   // NOTE: state is updated with non-blocking assignments so every counter reads its pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the counter array is reset explicitly; a stale count would stall ID forever.
         for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
         sb_ovf <= 1'b0;
      end else begin
         if (refuse) sb_ovf <= 1'b1;
         if (do_issue && !same_reg && !refuse)
            cnt[issue_addr] <= cnt[issue_addr] + CNT_ONE;
         if (do_commit && !same_reg && (cnt[commit_addr] != '0))
            cnt[commit_addr] <= cnt[commit_addr] - CNT_ONE;
      end
   end

   always_comb begin
      // NOTE: default first so the combinational outputs never infer a latch.
      busy = '0;
      for (int i = 0; i < NRD; i++) begin
         busy[i] = (cnt[raddr[i*ADDR_W +: ADDR_W]] != '0) &&
                   !(fwd[i] && (cnt[raddr[i*ADDR_W +: ADDR_W]] == CNT_ONE));
      end
   end

endmodule

// File: rtl/regfile_mport.sv
// Multi-read-port register file with write-back mux, syscall read override and hazard scoreboard.
// Define REGFILE_MPORT_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_mport
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int CNT_W  = 2
) (
   input  logic                  in_clk,
   input  logic                  in_RST,
   input  logic [NRD*ADDR_W-1:0] in_raddr,
   input  logic                  in_syscall,
   output logic [NRD*DATA_W-1:0] out_rdata,
   output logic [NRD-1:0]        out_hazard,
   input  logic                  in_issue,
   input  logic [ADDR_W-1:0]     in_issue_addr,
   output logic                  out_sb_ovf,
   input  logic                  in_we,
   input  logic [1:0]            in_wsrc,
   input  logic [ADDR_W-1:0]     in_waddr,
   input  logic [DATA_W-1:0]     in_alu,
   input  logic [DATA_W-1:0]     in_mem,
   input  logic [DATA_W-1:0]     in_pc
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]     regs [DEPTH];
   logic [ADDR_W-1:0]     waddr_eff;
   logic [DATA_W-1:0]     wdata;
   logic                  wr_en;
   logic [ADDR_W-1:0]     raddr_eff [NRD];
   logic [NRD*ADDR_W-1:0] raddr_flat;
   logic [NRD-1:0]        fwd;

   always_comb begin
      case (wb_src_e'(in_wsrc))
         WB_SRC_MEM:  wdata = in_mem;
         WB_SRC_LINK: wdata = in_pc + DATA_W'(1);
         default:     wdata = in_alu;
      endcase
      waddr_eff = (wb_src_e'(in_wsrc) == WB_SRC_LINK) ? ADDR_W'(REG_RA) : in_waddr;
      wr_en     = in_we && (waddr_eff != ADDR_W'(REG_ZERO));
   end

   always_ff @(posedge in_clk) begin
      if (in_RST) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else if (wr_en) begin
         regs[waddr_eff] <= wdata;
      end
   end

   always_comb begin
      out_rdata  = '0;
      raddr_flat = '0;
      fwd        = '0;
      for (int i = 0; i < NRD; i++) begin
         raddr_eff[i] = in_raddr[i*ADDR_W +: ADDR_W];
         // Syscall handler reads its number from v0 and its argument from a0.
         if (in_syscall && (i == 0)) raddr_eff[i] = ADDR_W'(REG_V0);
         if (in_syscall && (i == 1)) raddr_eff[i] = ADDR_W'(REG_A0);
         raddr_flat[i*ADDR_W +: ADDR_W] = raddr_eff[i];
         out_rdata[i*DATA_W +: DATA_W]  = regs[raddr_eff[i]];
`ifdef REGFILE_MPORT_BYPASS_EN
         if (wr_en && (raddr_eff[i] == waddr_eff)) begin
            out_rdata[i*DATA_W +: DATA_W] = wdata;
            fwd[i] = 1'b1;
         end
`else
`endif
      end
   end

   regfile_sb #(
      .ADDR_W (ADDR_W),
      .NRD    (NRD),
      .CNT_W  (CNT_W)
   ) u_sb (
      .clk         (in_clk),
      .rst         (in_RST),
      .issue       (in_issue),
      .issue_addr  (in_issue_addr),
      .commit      (in_we),
      .commit_addr (waddr_eff),
      .raddr       (raddr_flat),
      .fwd         (fwd),
      .busy        (out_hazard),
      .sb_ovf      (out_sb_ovf)
   );

endmodule

// File: tb/tb_regfile_mport.sv
// Self-checking bench for regfile_mport: directed steps then random traffic against a behavioural model.
module tb_regfile_mport;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NRD    = 2;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                  in_clk;
   logic                  in_RST;
   logic [NRD*ADDR_W-1:0] in_raddr;
   logic                  in_syscall;
   logic [NRD*DATA_W-1:0] out_rdata;
   logic [NRD-1:0]        out_hazard;
   logic                  in_issue;
   logic [ADDR_W-1:0]     in_issue_addr;
   logic                  out_sb_ovf;
   logic                  in_we;
   logic [1:0]            in_wsrc;
   logic [ADDR_W-1:0]     in_waddr;
   logic [DATA_W-1:0]     in_alu;
   logic [DATA_W-1:0]     in_mem;
   logic [DATA_W-1:0]     in_pc;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [DATA_W-1:0] m_regs [32];
   int                m_cnt  [32];
   logic              m_ovf;

   regfile_mport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)) dut (
      .in_clk(in_clk), .in_RST(in_RST), .in_raddr(in_raddr), .in_syscall(in_syscall),
      .out_rdata(out_rdata), .out_hazard(out_hazard), .in_issue(in_issue),
      .in_issue_addr(in_issue_addr), .out_sb_ovf(out_sb_ovf), .in_we(in_we),
      .in_wsrc(in_wsrc), .in_waddr(in_waddr), .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int wb_addr();
      return (in_wsrc == 2'd2) ? 31 : int'(in_waddr);
   endfunction

   function automatic logic [DATA_W-1:0] wb_data();
      if (in_wsrc == 2'd0) return in_mem;
      if (in_wsrc == 2'd2) return in_pc + 1;
      return in_alu;
   endfunction

   function automatic int port_addr(int i);
      if (in_syscall && i == 0) return 2;
      if (in_syscall && i == 1) return 4;
      return int'(in_raddr[i*ADDR_W +: ADDR_W]);
   endfunction

   function automatic logic [DATA_W-1:0] exp_rdata(int i);
      int a = port_addr(i);
`ifdef REGFILE_MPORT_BYPASS_EN
      if (in_we && a != 0 && a == wb_addr()) return wb_data();
`endif
      return (a == 0) ? '0 : m_regs[a];
   endfunction

   function automatic logic exp_hazard(int i);
      int a = port_addr(i);
`ifdef REGFILE_MPORT_BYPASS_EN
      if (in_we && a != 0 && a == wb_addr() && m_cnt[a] == 1) return 1'b0;
`endif
      return m_cnt[a] != 0;
   endfunction

   task automatic check_outputs(input string tag);
      for (int i = 0; i < NRD; i++) begin
         check($sformatf("%s rdata%0d a=%0d", tag, i, port_addr(i)), out_rdata[i*DATA_W +: DATA_W], exp_rdata(i));
         check($sformatf("%s hazard%0d a=%0d", tag, i, port_addr(i)), {31'd0, out_hazard[i]}, {31'd0, exp_hazard(i)});
      end
      check({tag, " sb_ovf"}, {31'd0, out_sb_ovf}, {31'd0, m_ovf});
   endtask

   // Apply the effect of the current inputs at the coming edge to the model, then cross the edge.
   task automatic tick();
      if (in_RST) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
         end
         m_ovf = 1'b0;
      end else begin
         int  wa  = wb_addr();
         int  ia  = int'(in_issue_addr);
         bit  com = in_we && wa != 0;
         bit  iss = in_issue && ia != 0;
         if (com) m_regs[wa] = wb_data();
         if (!(iss && com && ia == wa)) begin
            if (iss) begin
               if (m_cnt[ia] == CMAX) m_ovf = 1'b1;
               else m_cnt[ia] = m_cnt[ia] + 1;
            end
            if (com && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
         end
      end
      @(posedge in_clk);
      #1;
   endtask

   task automatic idle();
      in_RST = 0; in_we = 0; in_issue = 0; in_syscall = 0;
      in_wsrc = 2'd1; in_waddr = '0; in_issue_addr = '0;
      in_alu = '0; in_mem = '0; in_pc = '0;
   endtask

   task automatic commit(input logic [1:0] src, input int addr, input logic [DATA_W-1:0] val);
      in_we = 1; in_wsrc = src; in_waddr = ADDR_W'(addr);
      in_alu = val; in_mem = val; in_pc = val;
      tick();
      in_we = 0;
   endtask

   task automatic issue(input int addr);
      in_issue = 1; in_issue_addr = ADDR_W'(addr);
      tick();
      in_issue = 0;
   endtask

   task automatic read2(input int a0, input int a1);
      in_raddr = {ADDR_W'(a1), ADDR_W'(a0)};
      #1;
   endtask

   initial begin
      idle();
      in_raddr = '0;
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 'x;
         m_cnt[r]  = 0;
      end
      m_ovf = 1'b0;

      // Reset, then sweep every register on both ports
      @(posedge in_clk); #1;
      in_RST = 1;
      tick();
      tick();
      in_RST = 0;
      for (int a = 0; a < 32; a++) begin
         read2(a, 31 - a);
         check_outputs("reset_sweep");
      end

      // ALU commit to 5, visible next cycle; commits to 0 are dropped
      commit(2'd1, 5, 32'hDEADBEEF);
      read2(5, 0);
      check_outputs("alu_wr5");
      check("alu_wr5 literal", out_rdata[0 +: DATA_W], 32'hDEADBEEF);
      commit(2'd1, 0, 32'h12345678);
      read2(0, 5);
      check_outputs("wr0_dropped");
      check("wr0 literal", out_rdata[0 +: DATA_W], 32'h0);

      // Link write goes to 31 with wrapped PC+1; waddr 7 untouched
      commit(2'd1, 7, 32'h00000077);
      commit(2'd1, 31, 32'hAAAA5555);
      commit(2'd2, 7, 32'hFFFFFFFF);
      read2(31, 7);
      check_outputs("link");
      check("link r31 literal", out_rdata[0 +: DATA_W], 32'h0);
      check("link r7 literal", out_rdata[DATA_W +: DATA_W], 32'h77);
      commit(2'd0, 8, 32'hCAFEF00D);
      read2(8, 8);
      check_outputs("mem_wr8");

      // Scoreboard counting, underflow tolerance and saturation
      read2(9, 10);
      issue(9);
      issue(9);
      check_outputs("sb_two_pending");
      check("sb hazard9 literal", {31'd0, out_hazard[0]}, 32'd1);
      commit(2'd1, 9, 32'h9);
      check_outputs("sb_one_pending");
      commit(2'd1, 9, 32'h99);
      check_outputs("sb_cleared");
      check("sb cleared literal", {31'd0, out_hazard[0]}, 32'd0);
      commit(2'd1, 10, 32'h10);
      check_outputs("sb_underflow");
      issue(10);
      check_outputs("sb_after_underflow");
      issue(9); issue(9); issue(9);
      check_outputs("sb_at_max");
      check("ovf before refuse", {31'd0, out_sb_ovf}, 32'd0);
      issue(9);
      check_outputs("sb_refused");
      check("ovf after refuse", {31'd0, out_sb_ovf}, 32'd1);
      tick(); tick();
      check_outputs("sb_ovf_sticky");
      in_issue = 1; in_issue_addr = '0;
      tick();
      in_issue = 0;
      read2(0, 9);
      check_outputs("issue_to_0");

      // Syscall overrides ports 0 and 1
      commit(2'd1, 2, 32'h11);
      commit(2'd1, 4, 32'h22);
      in_syscall = 1;
      read2(17, 9);
      check_outputs("syscall");
      check("syscall p0 literal", out_rdata[0 +: DATA_W], 32'h11);
      check("syscall p1 literal", out_rdata[DATA_W +: DATA_W], 32'h22);
      in_syscall = 0;

      // Same-cycle commit and read of a single pending register
      issue(3);
      in_we = 1; in_wsrc = 2'd1; in_waddr = 5'd3; in_alu = 32'h55;
      read2(3, 3);
      check_outputs("same_cycle");
`ifdef REGFILE_MPORT_BYPASS_EN
      check("bypass data literal", out_rdata[0 +: DATA_W], 32'h55);
      check("bypass hazard literal", {31'd0, out_hazard[0]}, 32'd0);
`else
      check("nobypass data literal", out_rdata[0 +: DATA_W], 32'h0);
      check("nobypass hazard literal", {31'd0, out_hazard[0]}, 32'd1);
`endif
      tick();
      in_we = 0;
      check_outputs("after_commit3");

      // Mid-operation reset discards pending counts; later commits leave counters at 0
      issue(12); issue(13);
      in_RST = 1;
      tick();
      in_RST = 0;
      read2(12, 13);
      check_outputs("reset_mid");
      commit(2'd1, 12, 32'hABCD);
      check_outputs("commit_after_reset");

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         in_RST        = ($urandom_range(0, 59) == 0);
         in_we         = $urandom_range(0, 1);
         in_wsrc       = 2'($urandom_range(0, 3));
         in_waddr      = ADDR_W'($urandom_range(0, 7));
         in_issue      = $urandom_range(0, 1);
         in_issue_addr = ADDR_W'($urandom_range(0, 7));
         in_syscall    = ($urandom_range(0, 7) == 0);
         in_alu        = $urandom;
         in_mem        = $urandom;
         in_pc         = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
         in_raddr      = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) == 0) in_raddr[ADDR_W +: ADDR_W] = 5'd31;
         #1;
         check_outputs($sformatf("rand%0d", n));
         tick();
      end
      idle();
      #1;
      check_outputs("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
